synfull_inject_queue: RTL

SYNFULL_INJECT_QUEUE -- requirements
Module: synfull_inject_queue

---
 rtl/dpi_int_pkg.sv | 22 ++
 rtl/synfull_inject_array.sv | 40 ++++
 rtl/synfull_req_fifo.sv | 54 +++++
 rtl/synfull_inject_queue.sv | 83 ++++++++
 4 files changed

// File: rtl/dpi_int_pkg.sv
// Shared types and default constants for the DPI-to-NI trace-injection path.
// req_t is the single request format used on both sides of the inject queue.
package dpi_int_pkg;

   localparam int SYNFULL_INJQ_DEPTH = 4;
   localparam int SYNFULL_CNTW       = 32;
   localparam int SYNFULL_NE         = 32;

   localparam int DEST_W = 5;
   localparam int SRC_W  = 5;
   localparam int SIZE_W = 4;
   localparam int ID_W   = 8;

   typedef struct packed {
      logic              valid;
      logic [DEST_W-1:0] dest;
      logic [SRC_W-1:0]  src;
      logic [SIZE_W-1:0] size;
      logic [ID_W-1:0]   id;
   } req_t;

endpackage

// File: rtl/synfull_inject_array.sv
// One inject queue per network endpoint, sitting between the DPI interface
// and the NI ports.
module synfull_inject_array
   import dpi_int_pkg::*;
#(
   parameter int NE    = SYNFULL_NE,
   parameter int DEPTH = SYNFULL_INJQ_DEPTH,
   parameter int CNTW  = SYNFULL_CNTW
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  req_t                    dpi_req_i   [NE],
   output logic [NE-1:0]           dpi_ready_o,
   output req_t                    ni_req_o    [NE],
   input  logic [NE-1:0]           ni_ready_i,
   output logic [$clog2(DEPTH):0]  occupancy_o [NE],
   output logic [CNTW-1:0]         inj_cnt_o   [NE],
   output logic [CNTW-1:0]         drop_cnt_o  [NE],
   output logic [NE-1:0]           overflow_o
);

   for (genvar gi = 0; gi < NE; gi++) begin : g_ne
      synfull_inject_queue #(
         .DEPTH (DEPTH),
         .CNTW  (CNTW)
      ) u_q (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .req_i       (dpi_req_i[gi]),
         .ready_o     (dpi_ready_o[gi]),
         .req_o       (ni_req_o[gi]),
         .ni_ready_i  (ni_ready_i[gi]),
         .occupancy_o (occupancy_o[gi]),
         .inj_cnt_o   (inj_cnt_o[gi]),
         .drop_cnt_o  (drop_cnt_o[gi]),
         .overflow_o  (overflow_o[gi])
      );
   end

endmodule

// File: rtl/synfull_req_fifo.sv
// Generic first-word-fall-through FIFO: storage plus wrap-bit pointers.
// DEPTH must be a power of two and at least 2; the pointer MSB separates
// full from empty once the address bits wrap.
module synfull_req_fifo #(
   parameter int  DEPTH  = 4,
   parameter type data_t = logic [7:0]
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  data_t                    wr_data,
   input  logic                     pop,
   output data_t                    rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        push_ok;
   logic        pop_ok;

   data_t mem [DEPTH];

   // Guard against a caller pushing into full or popping from empty.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointer advance; both pointers clear together so queued data is discarded.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage write; contents need no reset because the head is masked when empty.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg[AW-1:0]];
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count   = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/synfull_inject_queue.sv
// Per-NE inject queue between the trace-injection stage and the ProNoC NI.
// Requests arriving while full are dropped and counted; the head is presented
// first-word-fall-through with zeroed fields when nothing is queued.
module synfull_inject_queue
   import dpi_int_pkg::*;
#(
   parameter int DEPTH = SYNFULL_INJQ_DEPTH,
   parameter int CNTW  = SYNFULL_CNTW
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  req_t                    req_i,
   output logic                    ready_o,
   output req_t                    req_o,
   input  logic                    ni_ready_i,
   output logic [$clog2(DEPTH):0]  occupancy_o,
   output logic [CNTW-1:0]         inj_cnt_o,
   output logic [CNTW-1:0]         drop_cnt_o,
   output logic                    overflow_o
);

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            drop;
   req_t            head;
   logic [CNTW-1:0] inj_cnt_reg;
   logic [CNTW-1:0] drop_cnt_reg;
   logic            overflow_reg;

   // Full is taken before this cycle's pop, so a pop never makes room for a
   // push in the same cycle.
   assign push = req_i.valid && !full;
   assign drop = req_i.valid && full;
   assign pop  = !empty && ni_ready_i;

   synfull_req_fifo #(
      .DEPTH  (DEPTH),
      .data_t (req_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push),
      .wr_data (req_i),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (occupancy_o)
   );

   // Saturating statistics and the sticky overflow flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inj_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (pop && (inj_cnt_reg != '1))
            inj_cnt_reg <= inj_cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
         if (drop && (drop_cnt_reg != '1))
            drop_cnt_reg <= drop_cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

   // Head presentation: zero everything when empty, otherwise the stored entry.
   always_comb begin
      req_o = '0;
      if (!empty) begin
         req_o       = head;
         req_o.valid = 1'b1;
      end
   end

   assign ready_o    = !full;
   assign inj_cnt_o  = inj_cnt_reg;
   assign drop_cnt_o = drop_cnt_reg;
   assign overflow_o = overflow_reg;

endmodule
